// File: rtl/scan_doubler_if.sv
// Video stream bundle between the ULA pixel generator, the scan doubler and the VGA output.
// Latency: none (wiring only).
// Backpressure: none; the video stream is free-running and paced by pixelCe.
interface scan_doubler_if;
    logic       pixelCe;
    logic [8:0] rgbIn;
    logic       hSyncIn;
    logic       vSyncIn;
    logic [8:0] rgbOut;
    logic       hSyncOut;
    logic       vSyncOut;
    logic       lineStart;

    // Pixel source side: drives the 7 MHz ULA stream and observes the doubled output.
    modport master (
        output pixelCe, rgbIn, hSyncIn, vSyncIn,
        input  rgbOut, hSyncOut, vSyncOut, lineStart
    );

    // Scan doubler side.
    modport slave (
        input  pixelCe, rgbIn, hSyncIn, vSyncIn,
        output rgbOut, hSyncOut, vSyncOut, lineStart
    );
endinterface

// File: rtl/scan_doubler.sv
// Line doubler: captures each 15.6 kHz ULA line into a ping-pong buffer and replays it twice at 31.2 kHz.
// Latency: rgbOut/hSyncOut/vSyncOut trail the read pointer by 2 clocks; video trails input by one input line.
// Backpressure: none; writes follow pixelCe, reads free-run every clock and restart on each input hsync edge.
module scan_doubler #(
    parameter int LINE   = 448,
    parameter int HS_LEN = 53,
    parameter int AW     = 9
) (
    input  logic          clock,
    input  logic          reset,
    scan_doubler_if.slave vid
);

    localparam logic [AW-1:0] LAST   = AW'(LINE - 1);
    localparam logic [AW-1:0] HS_CMP = AW'(HS_LEN);

    // Line capture / replay state
    logic          hPrev_q, hPrev_d;
    logic          wrBank_q, wrBank_d;
    logic [AW-1:0] wrX_q, wrX_d;
    logic          rdBank_q, rdBank_d;
    logic [AW-1:0] rdX_q, rdX_d;
    logic          vLatch_q, vLatch_d;
    logic          lineStart_q, lineStart_d;

    // Output pipeline
    logic          pipeVld_q;
    logic [AW-1:0] rdXP1_q;
    logic          vLatchP1_q;
    logic [8:0]    rdDat_q;
    logic [8:0]    rgbOut_q;
    logic          hSyncOut_q;
    logic          vSyncOut_q;

    logic          hsEdge;
    logic          wrEn;

    // Ping-pong line store: bank selected by wrBank/rdBank, one line per bank.
    logic [8:0]    mem [0:1][0:LINE-1];

    // Falling hsync on a pixel slot starts a new line; the edge pixel itself is never stored.
    always_comb begin
        hsEdge      = vid.pixelCe & hPrev_q & ~vid.hSyncIn;
        wrEn        = vid.pixelCe & ~hsEdge;
        hPrev_d     = hPrev_q;
        wrBank_d    = wrBank_q;
        wrX_d       = wrX_q;
        rdBank_d    = rdBank_q;
        rdX_d       = rdX_q;
        vLatch_d    = vLatch_q;
        lineStart_d = hsEdge;

        if (vid.pixelCe) begin
            hPrev_d = vid.hSyncIn;
        end

        if (hsEdge) begin
            wrBank_d = ~wrBank_q;
            wrX_d    = '0;
            rdBank_d = wrBank_q;
            rdX_d    = '0;
            vLatch_d = vid.vSyncIn;
        end else begin
            // Over-long lines pile up on the last address instead of wrapping into the line start.
            if (wrEn && (wrX_q != LAST)) begin
                wrX_d = wrX_q + 1'b1;
            end
            rdX_d = (rdX_q == LAST) ? '0 : rdX_q + 1'b1;
        end
    end

    // Capture/replay state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hPrev_q     <= 1'b1;
            wrBank_q    <= 1'b0;
            wrX_q       <= '0;
            rdBank_q    <= 1'b0;
            rdX_q       <= '0;
            vLatch_q    <= 1'b1;
            lineStart_q <= 1'b0;
        end else begin
            hPrev_q     <= hPrev_d;
            wrBank_q    <= wrBank_d;
            wrX_q       <= wrX_d;
            rdBank_q    <= rdBank_d;
            rdX_q       <= rdX_d;
            vLatch_q    <= vLatch_d;
            lineStart_q <= lineStart_d;
        end
    end

    // Line buffer: synchronous write of the capture bank, synchronous read of the replay bank.
    always_ff @(posedge clock) begin
        if (reset && wrEn) begin
            mem[wrBank_q][wrX_q] <= vid.rgbIn;
        end
        rdDat_q <= mem[rdBank_q][rdX_q];
    end

    // Two-stage output pipeline; pipeVld keeps the first post-reset stage from leaking stale sync.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pipeVld_q  <= 1'b0;
            rdXP1_q    <= '0;
            vLatchP1_q <= 1'b1;
            rgbOut_q   <= '0;
            hSyncOut_q <= 1'b1;
            vSyncOut_q <= 1'b1;
        end else begin
            pipeVld_q  <= 1'b1;
            rdXP1_q    <= rdX_q;
            vLatchP1_q <= vLatch_q;
            rgbOut_q   <= pipeVld_q ? rdDat_q : 9'd0;
            hSyncOut_q <= pipeVld_q ? !(rdXP1_q < HS_CMP) : 1'b1;
            vSyncOut_q <= pipeVld_q ? vLatchP1_q : 1'b1;
        end
    end

    assign vid.rgbOut    = rgbOut_q;
    assign vid.hSyncOut  = hSyncOut_q;
    assign vid.vSyncOut  = vSyncOut_q;
    assign vid.lineStart = lineStart_q;

endmodule
